// File: rtl/serial_subtractor_pkg.sv
// Shared types and the arithmetic reference for the bit-serial subtractor.
// ref_sub returns {borrow, diff} for operands of the given width (1..64).
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH:0] ref_sub(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 bin,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH:0]   a_ext;
        logic [MAX_WIDTH:0]   b_ext;
        logic [MAX_WIDTH-1:0] diff;
        logic                 borrow;
        mask   = (width >= MAX_WIDTH) ? '1
               : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        a_ext  = {1'b0, a & mask};
        b_ext  = {1'b0, b & mask} + {{MAX_WIDTH{1'b0}}, bin};
        borrow = (a_ext < b_ext);
        diff   = (a - b - {{(MAX_WIDTH-1){1'b0}}, bin}) & mask;
        return {borrow, diff};
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// Single-bit full subtractor cell: computes i_a - i_b - i_c.
// o_borrow is set when the bit position must borrow from the next one.
module fullsub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_a ^ i_b ^ i_c;
    assign o_borrow = (~i_a & i_b) | (~i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one fullsub cell, LSB first, one bit per
// clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_diff;
    logic             cell_borrow;

    fullsub u_fullsub (
        .i_a      (a_sr[0]),
        .i_b      (b_sr[0]),
        .i_c      (borrow_q),
        .o_diff   (cell_diff),
        .o_borrow (cell_borrow)
    );

    // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sr     <= i_a;
                        b_sr     <= i_b;
                        borrow_q <= i_bin;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr   <= {cell_diff, res_sr[WIDTH-1:1]};
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    borrow_q <= cell_borrow;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_busy   = (state != IDLE);
    assign o_diff   = res_sr;
    assign o_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed handshake/reset cases followed by
// randomized operations with stalls, checked against plain-arithmetic expectations.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_busy;

    int               checks;
    int               fails;
    logic [WIDTH-1:0] last_diff;
    logic             last_borrow;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_bin    (i_bin),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction; with junk set, inputs are scrambled while busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input int stall, input bit junk);
        logic [64:0]      expv;
        logic [WIDTH-1:0] held_diff;
        logic             held_borrow;
        int               cycles;
        expv = ref_sub(64'(a), 64'(b), bin, WIDTH);
        @(negedge clk);
        checkOutput("ready_idle", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_bin   = bin;
        @(negedge clk);
        i_valid = 1'b0;
        cycles  = 0;
        while (!o_valid && cycles < 4 * WIDTH) begin
            if (junk) begin
                checkOutput("ready_low_shift", 64'(o_ready), 64'd0);
                checkOutput("busy_shift", 64'(o_busy), 64'd1);
                i_valid = 1'($urandom);
                i_a     = WIDTH'($urandom);
                i_b     = WIDTH'($urandom);
                i_bin   = 1'($urandom);
                i_ready = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        checkOutput("latency", 64'(cycles), 64'(WIDTH));
        held_diff   = o_diff;
        held_borrow = o_borrow;
        for (int s = 0; s < stall; s++) begin
            if (junk) begin
                i_valid = 1'b1;
                i_a     = WIDTH'($urandom);
                i_b     = WIDTH'($urandom);
                i_bin   = 1'($urandom);
            end
            @(negedge clk);
            checkOutput("stall_valid", 64'(o_valid), 64'd1);
            checkOutput("stall_ready", 64'(o_ready), 64'd0);
            checkOutput("stall_diff", 64'(o_diff), 64'(held_diff));
            checkOutput("stall_borrow", 64'(o_borrow), 64'(held_borrow));
        end
        i_valid = 1'b0;
        checkOutput("diff", 64'(o_diff), 64'(expv[WIDTH-1:0]));
        checkOutput("borrow", 64'(o_borrow), 64'(expv[64]));
        last_diff   = o_diff;
        last_borrow = o_borrow;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        checkOutput("valid_drop", 64'(o_valid), 64'd0);
        checkOutput("ready_back", 64'(o_ready), 64'd1);
    endtask

    initial begin
        int  stray_valid;
        checks  = 0;
        fails   = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_bin   = 1'b0;
        i_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(o_ready), 64'd1);
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_diff", 64'(o_diff), 64'h00);
        checkOutput("rst_borrow", 64'(o_borrow), 64'd0);
        rst = 1'b0;

        applyStimulus(8'h35, 8'h12, 1'b0, 0, 1'b0);
        checkOutput("basic_diff", 64'(last_diff), 64'h23);
        checkOutput("basic_borrow", 64'(last_borrow), 64'd0);

        applyStimulus(8'h00, 8'h01, 1'b0, 0, 1'b0);
        checkOutput("wrap_diff", 64'(last_diff), 64'hFF);
        checkOutput("wrap_borrow", 64'(last_borrow), 64'd1);

        applyStimulus(8'h80, 8'h7F, 1'b1, 0, 1'b0);
        checkOutput("bin_zero_diff", 64'(last_diff), 64'h00);
        checkOutput("bin_zero_borrow", 64'(last_borrow), 64'd0);

        applyStimulus(8'h10, 8'h10, 1'b1, 0, 1'b0);
        checkOutput("bin_wrap_diff", 64'(last_diff), 64'hFF);
        checkOutput("bin_wrap_borrow", 64'(last_borrow), 64'd1);

        applyStimulus(8'hC3, 8'h41, 1'b0, 5, 1'b1);
        checkOutput("stall_result", 64'(last_diff), 64'h82);

        // Reset lands on the third shift edge; the result must never appear.
        @(negedge clk);
        i_valid = 1'b1;
        i_a     = 8'hFF;
        i_b     = 8'h01;
        i_bin   = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ready", 64'(o_ready), 64'd1);
        checkOutput("midrst_busy", 64'(o_busy), 64'd0);
        checkOutput("midrst_valid", 64'(o_valid), 64'd0);
        checkOutput("midrst_diff", 64'(o_diff), 64'h00);
        stray_valid = 0;
        repeat (2 * WIDTH) begin
            @(negedge clk);
            if (o_valid) stray_valid++;
        end
        checkOutput("midrst_no_valid", 64'(stray_valid), 64'd0);

        applyStimulus(8'hA5, 8'h5A, 1'b0, 0, 1'b0);
        checkOutput("post_rst_diff", 64'(last_diff), 64'h4B);
        checkOutput("post_rst_borrow", 64'(last_borrow), 64'd0);

        for (int n = 0; n < 1000; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
